// File: rtl/sweep_scheduler_if.sv
// Host/VNA/switch-side signal bundle for sweep_scheduler.
// The master modport drives commands and VNA_RDY; the slave modport is the scheduler.
interface sweep_scheduler_if;
  logic       start;
  logic       abort;
  logic [2:0] port_mask;
  logic [7:0] n_sweeps;
  logic       VNA_RDY;
  logic       VNA_TRIG;
  logic       sw_J1;
  logic       sw_J2;
  logic       sw_J3;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [1:0] cur_port;
  logic [7:0] sweep_cnt;

  modport master (
    output start, abort, port_mask, n_sweeps, VNA_RDY,
    input  VNA_TRIG, sw_J1, sw_J2, sw_J3, busy, done, timeout_err, cur_port, sweep_cnt
  );

  modport slave (
    input  start, abort, port_mask, n_sweeps, VNA_RDY,
    output VNA_TRIG, sw_J1, sw_J2, sw_J3, busy, done, timeout_err, cur_port, sweep_cnt
  );
endinterface

// File: rtl/sweep_scheduler.sv
// Steps the J1/J2/J3 RF switch and VNA trigger through a port mask for n passes.
// Optional macro TRIG_RETRY_EN: one trigger retry per port before declaring a timeout.
module sweep_scheduler #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TRIG_HIGH      = 25,
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int CNT_W          = 24
) (
  input logic              Clk,
  input logic              Rst,
  sweep_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT_RDY, NEXT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             trig_reg, trig_next;
  logic [1:0]       port_reg, port_next;
  logic [7:0]       sweep_reg, sweep_next;
  logic             done_reg, done_next;
  logic             terr_reg, terr_next;
  logic [2:0]       mask_reg, mask_next;
  logic [7:0]       nsw_reg, nsw_next;
  logic [2:0]       sw_reg, sw_next;
`ifdef TRIG_RETRY_EN
  logic             retry_reg, retry_next;
`endif

  logic rdy_s1_reg, rdy_s2_reg, rdy_s3_reg;
  logic rdy_edge;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rdy_s1_reg <= 1'b0;
      rdy_s2_reg <= 1'b0;
      rdy_s3_reg <= 1'b0;
    end else begin
      rdy_s1_reg <= bus.VNA_RDY;
      rdy_s2_reg <= rdy_s1_reg;
      rdy_s3_reg <= rdy_s2_reg;
    end
  end

  assign rdy_edge = rdy_s2_reg & ~rdy_s3_reg;

  function automatic logic [1:0] lowest_set(input logic [2:0] m);
    logic [1:0] r;
    logic       found;
    r     = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && m[i]) begin
        r     = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Next set bit strictly above p; wraps to the lowest set bit.
  function automatic logic [1:0] next_set(input logic [2:0] m, input logic [1:0] p);
    logic [1:0] r;
    logic       found;
    r     = lowest_set(m);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && i > int'(p) && m[i]) begin
        r     = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic [1:0] nxt_port;
  logic       wrap;
  logic [7:0] sweep_inc;

  assign nxt_port  = next_set(mask_reg, port_reg);
  assign wrap      = (nxt_port <= port_reg);
  assign sweep_inc = sweep_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    trig_next  = trig_reg;
    port_next  = port_reg;
    sweep_next = sweep_reg;
    done_next  = 1'b0;
    terr_next  = terr_reg;
    mask_next  = mask_reg;
    nsw_next   = nsw_reg;
`ifdef TRIG_RETRY_EN
    retry_next = retry_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start && bus.port_mask != 3'b000) begin
          mask_next  = bus.port_mask;
          nsw_next   = bus.n_sweeps;
          port_next  = lowest_set(bus.port_mask);
          sweep_next = 8'd0;
          terr_next  = 1'b0;
          cnt_next   = '0;
`ifdef TRIG_RETRY_EN
          retry_next = 1'b0;
`endif
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_next   = '0;
          trig_next  = 1'b1;
          state_next = TRIG;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TRIG: begin
        if (cnt_reg == CNT_W'(TRIG_HIGH - 1)) begin
          cnt_next   = '0;
          trig_next  = 1'b0;
          state_next = WAIT_RDY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_RDY: begin
        // The edge is tested first so it beats a same-cycle timeout.
        if (rdy_edge) begin
          cnt_next   = '0;
          state_next = NEXT;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_next = '0;
`ifdef TRIG_RETRY_EN
          if (!retry_reg) begin
            retry_next = 1'b1;
            trig_next  = 1'b1;
            state_next = TRIG;
          end else begin
            terr_next  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end
`else
          terr_next  = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      NEXT: begin
`ifdef TRIG_RETRY_EN
        retry_next = 1'b0;
`endif
        if (wrap) sweep_next = sweep_inc;
        if (wrap && nsw_reg != 8'd0 && sweep_inc == nsw_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          port_next  = nxt_port;
          cnt_next   = '0;
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle start.
    if (bus.abort && state_reg != IDLE) begin
      state_next = IDLE;
      trig_next  = 1'b0;
      done_next  = 1'b0;
      cnt_next   = '0;
      port_next  = port_reg;
      sweep_next = sweep_reg;
      terr_next  = terr_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw_decode
    assign sw_next[gi] = (port_next == 2'(gi));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      trig_reg  <= 1'b0;
      port_reg  <= 2'd0;
      sweep_reg <= 8'd0;
      done_reg  <= 1'b0;
      terr_reg  <= 1'b0;
      mask_reg  <= 3'b000;
      nsw_reg   <= 8'd0;
      sw_reg    <= 3'b001;
`ifdef TRIG_RETRY_EN
      retry_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      trig_reg  <= trig_next;
      port_reg  <= port_next;
      sweep_reg <= sweep_next;
      done_reg  <= done_next;
      terr_reg  <= terr_next;
      mask_reg  <= mask_next;
      nsw_reg   <= nsw_next;
      sw_reg    <= sw_next;
`ifdef TRIG_RETRY_EN
      retry_reg <= retry_next;
`endif
    end
  end

  assign bus.VNA_TRIG    = trig_reg;
  assign bus.sw_J1       = sw_reg[0];
  assign bus.sw_J2       = sw_reg[1];
  assign bus.sw_J3       = sw_reg[2];
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.timeout_err = terr_reg;
  assign bus.cur_port    = port_reg;
  assign bus.sweep_cnt   = sweep_reg;

endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Sequences the three-way RF switch (J1/J2/J3) and the VNA trigger through a programmable port list, for a set number of passes.
- Flow per port: select port -> wait for switch settling -> pulse VNA_TRIG -> wait for VNA_RDY rising edge -> advance to next enabled port.
- Sits between the host command decoder (start, mask, count) and the switch drivers / VNA trigger pin.
- Reports busy, done, timeout and progress.

Parameters:
- SETTLE_CYCLES, 1000, Clk cycles between switch change and trigger start.
- TRIG_HIGH, 25, Clk cycles VNA_TRIG is held high.
- TIMEOUT_CYCLES, 10000000, max Clk cycles in WAIT_RDY before error.
- CNT_W, 24, width of the shared delay/timeout counter; must hold max(SETTLE_CYCLES, TRIG_HIGH, TIMEOUT_CYCLES).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- abort  in  1  single-cycle request to stop the run immediately.
- port_mask  in  3  bit0=J1, bit1=J2, bit2=J3; sampled on an accepted start.
- n_sweeps  in  8  number of full passes; 0 = run continuously until abort. Sampled on an accepted start.
- VNA_RDY  in  1  asynchronous ready level from the VNA.
- VNA_TRIG  out  1  registered trigger pulse.
- sw_J1, sw_J2, sw_J3  out  1 each  registered one-hot switch select.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at run end: normal completion or timeout.
- timeout_err  out  1  sticky; cleared by the next accepted start.
- cur_port  out  2  active port index, 0..2.
- sweep_cnt  out  8  completed passes; wraps modulo 256.

Behaviour:
- Reset values: state IDLE, VNA_TRIG=0, sw_J1=1, sw_J2=0, sw_J3=0, cur_port=0, busy=0, done=0, timeout_err=0, sweep_cnt=0, all counters 0.
- VNA_RDY synchronisation: 2-flop synchroniser plus a third flop for edge detection. A rising edge is flagged 3 cycles after the pin transition.
- Rising edges outside WAIT_RDY are discarded.
- States: IDLE, SETTLE, TRIG, WAIT_RDY, NEXT.
- IDLE:
  - start with port_mask!=0 -> latch mask and n_sweeps, cur_port=lowest set bit, sweep_cnt=0, timeout_err=0, counter=0, go to SETTLE. Switch outputs update on the same edge.
  - start with port_mask==0 is ignored: no state change, no done pulse.
- SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, clear counter and go to TRIG.
- TRIG: VNA_TRIG=1 for exactly TRIG_HIGH cycles. Then VNA_TRIG=0, clear counter, go to WAIT_RDY.
- WAIT_RDY:
  - synced RDY rising edge -> NEXT.
  - counter reaches TIMEOUT_CYCLES-1 without an edge -> timeout_err=1, done pulse, go to IDLE.
  - Edge and timeout on the same cycle: the edge wins.
- NEXT (1 cycle): next port = next set bit of the latched mask above cur_port, wrapping to the lowest set bit.
  - Wrap or single-bit mask: this is a pass end, sweep_cnt+1.
  - n_sweeps!=0 and the incremented sweep_cnt equals n_sweeps: done pulse, go to IDLE. The switch stays on the last port.
  - Otherwise: update cur_port and go to SETTLE.
- start while busy: ignored.
- abort in any non-IDLE state:
  - go to IDLE on the next edge, VNA_TRIG=0 on that edge.
  - No done pulse. timeout_err unchanged. Switch holds its position.
  - abort and start on the same cycle: abort wins, start is discarded.
- Rst mid-run: immediate return to reset values.
- Exactly one sw_J* output is high at all times.

Optional Feature:
- Macro TRIG_RETRY_EN.
- Defined: the first timeout on a given port retries TRIG once (counter cleared, back to TRIG) instead of erroring. A second consecutive timeout on the same port sets timeout_err and ends the run. The retry flag clears in NEXT.
- Undefined: the first timeout ends the run as described in Behaviour.

Test Plan:
- Reset, then idle 10 cycles -> sw_J1=1, VNA_TRIG=0, busy=0, done=0.
- mask=3'b101, n_sweeps=2, VNA_RDY pulsed 50 cycles after each trigger falls:
  - port order 0,2,0,2.
  - 4 VNA_TRIG pulses, each TRIG_HIGH wide, each starting SETTLE_CYCLES after the switch change.
  - sweep_cnt ends at 2; one done pulse; busy falls on the same edge.
- mask=3'b010, n_sweeps=0, 5 RDY pulses then abort -> sw_J2 held, sweep_cnt=5, busy=0 next cycle, no done.
- VNA_RDY held low after a trigger -> timeout_err=1 and done exactly TIMEOUT_CYCLES cycles after WAIT_RDY entry (use a small TIMEOUT_CYCLES). A new start clears timeout_err.
- start with mask=0, and start while busy -> no state change in either case. Same-cycle start+abort while busy -> IDLE.
- TRIG_RETRY_EN defined, first RDY withheld, second provided -> 2 trigger pulses on the same port, no timeout_err, run continues.
